// File: rtl/rv32_pkg.sv
// rv32: shared RV32 datapath widths (word, register address, register count).
package rv32;
  localparam int unsigned REG_COUNT = 32;
  typedef logic [31:0]                    word;
  typedef logic [$clog2(REG_COUNT)-1:0]   gpr_addr_t;
endpackage

// File: rtl/wb_arbiter_pkg.sv
// lexington: writeback arbiter FSM encoding and default starvation limit.
package lexington;
  typedef enum logic {WB_NORMAL, WB_STARVED} wb_state_t;
  localparam int unsigned WB_STARVE_MAX_DEFAULT = 4;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: one pending bit per GPR for outstanding load destinations.
// x0 never becomes pending; a set and a clear to the same register in the
// same cycle leave the bit set (the new load supersedes the returning one).
module wb_scoreboard
  import rv32::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en,
  input  gpr_addr_t set_addr,
  input  logic      clr_en,
  input  gpr_addr_t clr_addr,
  input  gpr_addr_t rd_addr_a,
  input  gpr_addr_t rd_addr_b,
  output logic      pend_a,
  output logic      pend_b
);

  logic [REG_COUNT-1:0] pend;
  logic [REG_COUNT-1:0] pend_next;

  // Next pending vector: clear first so a same-cycle set overrides it.
  always_comb begin
    pend_next = pend;
    if (clr_en) pend_next[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) pend_next[set_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_next;
  end

  // Lookup ports read the current (registered) state.
  always_comb begin
    pend_a = pend[rd_addr_a];
    pend_b = pend[rd_addr_b];
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates EXE and LSU writebacks onto the single GPR write
// port, registers the winner into a one-entry writeback stage, and reports
// decode read hazards from a load scoreboard.
// Optional feature macro: WB_FORWARD_EN (forward writeback-stage data to
// decode instead of stalling on it).
module wb_arbiter
  import rv32::*;
  import lexington::*;
#(
  parameter int unsigned STARVE_MAX = WB_STARVE_MAX_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      exe_valid,
  input  gpr_addr_t exe_addr,
  input  word       exe_data,
  output logic      exe_ready,
  input  logic      lsu_valid,
  input  gpr_addr_t lsu_addr,
  input  word       lsu_data,
  output logic      lsu_ready,
  input  logic      issue_en,
  input  gpr_addr_t issue_addr,
  input  gpr_addr_t rs1_addr,
  input  gpr_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      rs1_fwd_valid,
  output logic      rs2_fwd_valid,
  output word       fwd_data,
  output logic      dest_en,
  output gpr_addr_t dest_addr,
  output word       dest_data
);

  localparam logic [3:0] CNT_MAX = STARVE_MAX[3:0];

  wb_state_t  state, state_next;
  logic [3:0] starve_cnt, cnt_next;
  logic       grant_exe, grant_lsu;
  logic       rs1_pend, rs2_pend;
  logic       rs1_wb_hit, rs2_wb_hit;

  // Arbitration, starvation counter and FSM next-state.
  // The counter's next value decides the NORMAL->STARVED move so that EXE
  // wins on the cycle right after its STARVE_MAX-th loss.
  always_comb begin
    state_next = state;
    cnt_next   = starve_cnt;
    grant_exe  = 1'b0;
    grant_lsu  = 1'b0;
    case (state)
      WB_NORMAL: begin
        if (lsu_valid)      grant_lsu = 1'b1;
        else if (exe_valid) grant_exe = 1'b1;
      end
      WB_STARVED: begin
        if (exe_valid)      grant_exe = 1'b1;
        else if (lsu_valid) grant_lsu = 1'b1;
      end
      default: ;
    endcase
    if (!exe_valid || grant_exe)              cnt_next = '0;
    else if (grant_lsu && starve_cnt != CNT_MAX) cnt_next = starve_cnt + 4'd1;
    if (state == WB_NORMAL && exe_valid && cnt_next == CNT_MAX)
      state_next = WB_STARVED;
    else if (state == WB_STARVED && grant_exe)
      state_next = WB_NORMAL;
    exe_ready = grant_exe;
    lsu_ready = grant_lsu;
  end

  // FSM state and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WB_NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= cnt_next;
    end
  end

  // Writeback stage: capture the granted write; x0 writes never enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_en   <= 1'b0;
      dest_addr <= '0;
      dest_data <= '0;
    end else if (grant_exe) begin
      dest_en   <= (exe_addr != '0);
      dest_addr <= exe_addr;
      dest_data <= exe_data;
    end else if (grant_lsu) begin
      dest_en   <= (lsu_addr != '0);
      dest_addr <= lsu_addr;
      dest_data <= lsu_data;
    end else begin
      dest_en   <= 1'b0;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (issue_en),
    .set_addr  (issue_addr),
    .clr_en    (grant_lsu),
    .clr_addr  (lsu_addr),
    .rd_addr_a (rs1_addr),
    .rd_addr_b (rs2_addr),
    .pend_a    (rs1_pend),
    .pend_b    (rs2_pend)
  );

  // Read hazards against the scoreboard and the writeback stage.
  always_comb begin
    rs1_wb_hit = dest_en && (dest_addr == rs1_addr) && (rs1_addr != '0);
    rs2_wb_hit = dest_en && (dest_addr == rs2_addr) && (rs2_addr != '0);
`ifdef WB_FORWARD_EN
    rs1_fwd_valid = rs1_wb_hit && !rs1_pend;
    rs2_fwd_valid = rs2_wb_hit && !rs2_pend;
    fwd_data      = dest_data;
`else
    rs1_fwd_valid = 1'b0;
    rs2_fwd_valid = 1'b0;
    fwd_data      = '0;
`endif
    rs1_busy = (rs1_pend || rs1_wb_hit) && !rs1_fwd_valid;
    rs2_busy = (rs2_pend || rs2_wb_hit) && !rs2_fwd_valid;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter.
// Honours WB_FORWARD_EN to select the expected hazard/forwarding behaviour.
module tb_wb_arbiter;
  import rv32::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      exe_valid, lsu_valid, issue_en;
  gpr_addr_t exe_addr, lsu_addr, issue_addr, rs1_addr, rs2_addr;
  word       exe_data, lsu_data;
  logic      exe_ready, lsu_ready;
  logic      rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid;
  word       fwd_data;
  logic      dest_en;
  gpr_addr_t dest_addr;
  word       dest_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .exe_valid     (exe_valid),
    .exe_addr      (exe_addr),
    .exe_data      (exe_data),
    .exe_ready     (exe_ready),
    .lsu_valid     (lsu_valid),
    .lsu_addr      (lsu_addr),
    .lsu_data      (lsu_data),
    .lsu_ready     (lsu_ready),
    .issue_en      (issue_en),
    .issue_addr    (issue_addr),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs2_fwd_valid (rs2_fwd_valid),
    .fwd_data      (fwd_data),
    .dest_en       (dest_en),
    .dest_addr     (dest_addr),
    .dest_data     (dest_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock: inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exe_valid = 1'b0; exe_addr = '0; exe_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    issue_en  = 1'b0; issue_addr = '0;
  endtask

  initial begin
    logic fwd_on;
`ifdef WB_FORWARD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    rst_n = 1'b0;
    idle_inputs();
    rs1_addr = 5'd5; rs2_addr = 5'd0;

    // Reset state
    step(); step();
    chk("rst_dest_en",   32'(dest_en),   32'd0);
    chk("rst_dest_addr", 32'(dest_addr), 32'd0);
    chk("rst_dest_data", dest_data,      32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_exe_ready", 32'(exe_ready), 32'd0);
    chk("idle_lsu_ready", 32'(lsu_ready), 32'd0);
    chk("idle_rs1_busy",  32'(rs1_busy),  32'd0);
    chk("idle_rs2_busy",  32'(rs2_busy),  32'd0);

    // EXE only: x5 = DEADBEEF
    step();
    exe_valid = 1'b1; exe_addr = 5'd5; exe_data = 32'hDEADBEEF;
    #1;
    chk("exe_only_ready", 32'(exe_ready), 32'd1);
    chk("exe_only_lsu",   32'(lsu_ready), 32'd0);
    step();
    idle_inputs();
    #1;
    chk("exe_wb_en",   32'(dest_en),   32'd1);
    chk("exe_wb_addr", 32'(dest_addr), 32'd5);
    chk("exe_wb_data", dest_data,      32'hDEADBEEF);
    chk("exe_wb_busy", 32'(rs1_busy),  fwd_on ? 32'd0 : 32'd1);
    chk("exe_wb_fwdv", 32'(rs1_fwd_valid), fwd_on ? 32'd1 : 32'd0);
    chk("exe_wb_fwdd", fwd_data,       fwd_on ? 32'hDEADBEEF : 32'd0);
    step();
    #1;
    chk("exe_wb_en_off", 32'(dest_en),   32'd0);
    chk("exe_wb_hold",   32'(dest_addr), 32'd5);
    chk("exe_wb_busy0",  32'(rs1_busy),  32'd0);

    // Both valid continuously: L L L L E L
    rs1_addr = '0;
    exe_valid = 1'b1; exe_addr = 5'd10; exe_data = 32'h0000000A;
    lsu_valid = 1'b1; lsu_addr = 5'd11; lsu_data = 32'h0000000B;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("starve_lsu_%0d", i), 32'(lsu_ready), (i == 4) ? 32'd0 : 32'd1);
      chk($sformatf("starve_exe_%0d", i), 32'(exe_ready), (i == 4) ? 32'd1 : 32'd0);
      step();
      if (i == 4) begin
        chk("starve_wb_addr", 32'(dest_addr), 32'd10);
        chk("starve_wb_data", dest_data,      32'h0000000A);
      end
    end
    idle_inputs();
    step();

    // Counter clears when exe_valid drops: LLL, (L alone), LLLL, E
    lsu_valid = 1'b1; lsu_addr = 5'd11; lsu_data = 32'h0000000B;
    exe_addr = 5'd10; exe_data = 32'h0000000A;
    for (int i = 0; i < 9; i++) begin
      exe_valid = (i != 3);
      #1;
      chk($sformatf("clr_lsu_%0d", i), 32'(lsu_ready), (i == 8) ? 32'd0 : 32'd1);
      chk($sformatf("clr_exe_%0d", i), 32'(exe_ready), (i == 8) ? 32'd1 : 32'd0);
      step();
    end
    idle_inputs();
    step();

    // Load to x7: busy until the LSU returns it
    rs1_addr = 5'd7;
    issue_en = 1'b1; issue_addr = 5'd7;
    #1;
    chk("ld7_busy_issue", 32'(rs1_busy), 32'd0);
    step();
    issue_en = 1'b0;
    #1;
    chk("ld7_busy_pend", 32'(rs1_busy), 32'd1);
    step();
    lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'hCAFEF00D;
    #1;
    chk("ld7_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("ld7_busy_grant", 32'(rs1_busy), 32'd1);
    step();
    idle_inputs();
    #1;
    chk("ld7_wb_en",   32'(dest_en),       32'd1);
    chk("ld7_wb_busy", 32'(rs1_busy),      fwd_on ? 32'd0 : 32'd1);
    chk("ld7_wb_fwdv", 32'(rs1_fwd_valid), fwd_on ? 32'd1 : 32'd0);
    chk("ld7_wb_fwdd", fwd_data,           fwd_on ? 32'hCAFEF00D : 32'd0);
    step();
    #1;
    chk("ld7_done_busy", 32'(rs1_busy), 32'd0);

    // Same-cycle issue and LSU return to x3: set wins
    rs1_addr = '0; rs2_addr = 5'd3;
    issue_en = 1'b1; issue_addr = 5'd3;
    lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'h00000033;
    #1;
    chk("x3_lsu_ready", 32'(lsu_ready), 32'd1);
    step();
    idle_inputs();
    #1;
    chk("x3_busy_wb",  32'(rs2_busy),      32'd1);
    chk("x3_fwdv_wb",  32'(rs2_fwd_valid), 32'd0);
    step();
    #1;
    chk("x3_busy_pend", 32'(rs2_busy), 32'd1);

    // EXE write to x0: granted, never enabled
    exe_valid = 1'b1; exe_addr = 5'd0; exe_data = 32'h00001234;
    #1;
    chk("x0_exe_ready", 32'(exe_ready), 32'd1);
    chk("x0_rs1_busy",  32'(rs1_busy),  32'd0);
    step();
    idle_inputs();
    #1;
    chk("x0_dest_en",   32'(dest_en),       32'd0);
    chk("x0_rs1_fwdv",  32'(rs1_fwd_valid), 32'd0);

    // Drive into STARVED with dest_en=1 and x3 pending, then reset mid-stream
    exe_valid = 1'b1; exe_addr = 5'd9;  exe_data = 32'h00000099;
    lsu_valid = 1'b1; lsu_addr = 5'd12; lsu_data = 32'h000000CC;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_dest_en", 32'(dest_en), 32'd1);
    chk("pre_rst_busy",    32'(rs2_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dest_en",   32'(dest_en),   32'd0);
    chk("mid_rst_dest_addr", 32'(dest_addr), 32'd0);
    chk("mid_rst_dest_data", dest_data,      32'd0);
    chk("mid_rst_busy",      32'(rs2_busy),  32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("post_rst_exe_ready", 32'(exe_ready), 32'd0);
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
